mem_arbiter: RTL and testbench

//  Shares the single core memory port between the IFU (instruction fetch) and the LSU (load/store).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner tags
// and the latched request record.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;

    typedef enum logic [1:0] {NONE, IFU, LSU} arb_owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-way request picker with a one-hot grant {lsu, ifu}.
// MEM_ARB_RR_EN defined: round-robin, remembering the last winner.
// MEM_ARB_RR_EN undefined: fixed priority, LSU over IFU (IFU may starve).
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       upd_i,
`endif
    input  logic       ifu_req_i,
    input  logic       lsu_req_i,
    output logic [1:0] gnt_o
);

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_q, last_d;

    // On a tie, the master that did not win last time goes first.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (ifu_req_i && lsu_req_i)
            gnt_o = (last_q == LSU) ? 2'b01 : 2'b10;
        else if (lsu_req_i)
            gnt_o = 2'b10;
        else if (ifu_req_i)
            gnt_o = 2'b01;
        if (upd_i)
            last_d = gnt_o[1] ? LSU : IFU;
    end

    // Last-winner register; starts at IFU so the first tie goes to the LSU.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) last_q <= IFU;
        else        last_q <= last_d;
    end
`else
    // LSU always wins a tie.
    always_comb begin
        gnt_o = 2'b00;
        if (lsu_req_i)      gnt_o = 2'b10;
        else if (ifu_req_i) gnt_o = 2'b01;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU with a single outstanding
// transaction: IDLE (accept) -> REQ (issue) -> RESP (route back).
// Build option: MEM_ARB_RR_EN selects round-robin instead of LSU priority.
// The latched request uses the package widths; keep ADDR_W/DATA_W equal to them.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_rsp_valid_o,
    input  logic                ifu_rsp_ready_i,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_rsp_valid_o,
    input  logic                lsu_rsp_ready_i,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_rsp_valid_i,
    output logic                mem_rsp_ready_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    mem_req_t   req_q, req_d;
    logic [1:0] gnt;
    logic       ifu_hs, lsu_hs, in_idle;

    // Ready is also gated by reset so every output is low while rst_i is held.
    assign in_idle         = rst_i && (state_q == IDLE);
    assign ifu_req_ready_o = in_idle && gnt[0];
    assign lsu_req_ready_o = in_idle && gnt[1];
    assign ifu_hs          = ifu_req_valid_i && ifu_req_ready_o;
    assign lsu_hs          = lsu_req_valid_i && lsu_req_ready_o;

    arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .upd_i     (ifu_hs || lsu_hs),
`endif
        .ifu_req_i (ifu_req_valid_i),
        .lsu_req_i (lsu_req_valid_i),
        .gnt_o     (gnt)
    );

    // Memory side is driven only from the latched request.
    assign mem_req_valid_o = (state_q == REQ);
    assign mem_addr_o      = req_q.addr;
    assign mem_wen_o       = req_q.wen;
    assign mem_wdata_o     = req_q.wdata;
    assign mem_wmask_o     = req_q.wmask;

    // Response demux: zero-latency pass-through to the owner only.
    assign ifu_rsp_valid_o = (state_q == RESP) && (owner_q == IFU) && mem_rsp_valid_i;
    assign lsu_rsp_valid_o = (state_q == RESP) && (owner_q == LSU) && mem_rsp_valid_i;
    assign ifu_rdata_o     = ifu_rsp_valid_o ? mem_rdata_i : '0;
    assign lsu_rdata_o     = lsu_rsp_valid_o ? mem_rdata_i : '0;
    assign mem_rsp_ready_o = (state_q == RESP) &&
                             (((owner_q == IFU) && ifu_rsp_ready_i) ||
                              ((owner_q == LSU) && lsu_rsp_ready_i));

    // Next state, owner and request latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (ifu_hs) begin
                    req_d   = '{addr: ifu_addr_i, wen: 1'b0, wdata: '0, wmask: '0};
                    owner_d = IFU;
                    state_d = REQ;
                end else if (lsu_hs) begin
                    req_d   = '{addr: lsu_addr_i, wen: lsu_wen_i,
                                wdata: lsu_wdata_i, wmask: lsu_wmask_i};
                    owner_d = LSU;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready_i) state_d = RESP;
            end
            RESP: begin
                if (mem_rsp_valid_i && mem_rsp_ready_o) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= NONE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
        end
    end

`ifndef SYNTHESIS
    // Memory must not respond unless a request has been issued and accepted.
    a_rsp_outside_resp: assert property (@(posedge clk_i) disable iff (!rst_i)
        mem_rsp_valid_i |-> (state_q == RESP));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1ns after
// posedge; outputs are sampled on negedge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          ifu_req_valid_i = 0, ifu_req_ready_o, ifu_rsp_valid_o, ifu_rsp_ready_i = 0;
    logic [AW-1:0] ifu_addr_i = '0;
    logic [DW-1:0] ifu_rdata_o;
    logic          lsu_req_valid_i = 0, lsu_req_ready_o, lsu_wen_i = 0, lsu_rsp_valid_o, lsu_rsp_ready_i = 0;
    logic [AW-1:0] lsu_addr_i = '0;
    logic [DW-1:0] lsu_wdata_i = '0, lsu_rdata_o;
    logic [3:0]    lsu_wmask_i = '0;
    logic          mem_req_valid_o, mem_req_ready_i = 0, mem_wen_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i = '0;
    logic [3:0]    mem_wmask_o;
    logic          mem_rsp_valid_i = 0, mem_rsp_ready_o;

    int checks = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i(ifu_addr_i), .ifu_rsp_valid_o(ifu_rsp_valid_o),
        .ifu_rsp_ready_i(ifu_rsp_ready_i), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_wmask_i(lsu_wmask_i), .lsu_rsp_valid_o(lsu_rsp_valid_o),
        .lsu_rsp_ready_i(lsu_rsp_ready_i), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_ready_o(mem_rsp_ready_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    wire any_out = |{ifu_req_ready_o, ifu_rsp_valid_o, ifu_rdata_o, lsu_req_ready_o,
                     lsu_rsp_valid_o, lsu_rdata_o, mem_req_valid_o, mem_addr_o,
                     mem_wen_o, mem_wdata_o, mem_wmask_o, mem_rsp_ready_o};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid_i = 0; ifu_addr_i = '0; ifu_rsp_ready_i = 0;
        lsu_req_valid_i = 0; lsu_addr_i = '0; lsu_wen_i = 0; lsu_wdata_i = '0;
        lsu_wmask_i = '0; lsu_rsp_ready_i = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 0;
        repeat (2) tick();
        rst_i = 1;
    endtask

    task automatic test_reset();
        // Power-on reset with both masters requesting: nothing may be granted.
        clear_inputs();
        ifu_req_valid_i = 1; lsu_req_valid_i = 1;
        @(negedge clk_i);
        checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL por_outputs any_out=%b exp=0", any_out); end
        tick(); tick();
        clear_inputs(); rst_i = 1;
        // IFU read to 0x8000_0000, reset while in REQ.
        ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0000;
        @(negedge clk_i);
        checks++; if (ifu_req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_accept got=%b exp=1", ifu_req_ready_o); end
        tick();
        ifu_req_valid_i = 0;
        @(negedge clk_i);
        checks++; if ({mem_req_valid_o, mem_addr_o} !== {1'b1, 32'h8000_0000}) begin
            failures++; $display("FAIL rst_in_req got=%b/%h exp=1/80000000", mem_req_valid_o, mem_addr_o); end
        #1;
        rst_i = 0; ifu_req_valid_i = 1; lsu_req_valid_i = 1;
        #1;
        checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL rst_same_cycle any_out=%b exp=0", any_out); end
        tick();
        clear_inputs(); rst_i = 1;
        @(negedge clk_i);
        checks++; if ({mem_req_valid_o, mem_addr_o} !== 33'd0) begin
            failures++; $display("FAIL rst_release got=%b/%h exp=0/0", mem_req_valid_o, mem_addr_o); end
        #1;
        lsu_req_valid_i = 1;
        #1;
        checks++; if (lsu_req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_idle_ready got=%b exp=1", lsu_req_ready_o); end
        lsu_req_valid_i = 0;
        tick();
    endtask

    task automatic test_lsu_write();
        lsu_req_valid_i = 1; lsu_addr_i = 32'h8000_0100; lsu_wen_i = 1;
        lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF;
        @(negedge clk_i);
        checks++; if ({lsu_req_ready_o, ifu_req_ready_o} !== 2'b10) begin
            failures++; $display("FAIL wr_accept got=%b exp=10", {lsu_req_ready_o, ifu_req_ready_o}); end
        tick();
        // Scramble the master inputs: the latched copy must be used.
        lsu_req_valid_i = 0; lsu_addr_i = 32'h1; lsu_wen_i = 0; lsu_wdata_i = '0; lsu_wmask_i = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if ({mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o} !==
                {1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
                failures++;
                $display("FAIL wr_stall%0d got=%b %h %b %h %h exp=1 80000100 1 deadbeef f",
                         i, mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o);
            end
            tick();
        end
        mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'h1234_5678; lsu_rsp_ready_i = 1;
        @(negedge clk_i);
        checks++; if ({lsu_rsp_valid_o, ifu_rsp_valid_o, mem_rsp_ready_o} !== 3'b101) begin
            failures++; $display("FAIL wr_ack got=%b exp=101", {lsu_rsp_valid_o, ifu_rsp_valid_o, mem_rsp_ready_o}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_ifu_read();
        ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0004;
        lsu_wdata_i = 32'hFFFF_FFFF; lsu_wmask_i = 4'hF; lsu_wen_i = 1;
        @(negedge clk_i);
        checks++; if ({ifu_req_ready_o, mem_req_valid_o} !== 2'b10) begin
            failures++; $display("FAIL rd_accept got=%b exp=10", {ifu_req_ready_o, mem_req_valid_o}); end
        tick();
        ifu_req_valid_i = 0; mem_req_ready_i = 1;
        @(negedge clk_i);
        checks++;
        if ({mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, ifu_rsp_valid_o} !==
            {1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL rd_req got=%b %h %b %h %h %b exp=1 80000004 0 0 0 0",
                     mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, ifu_rsp_valid_o);
        end
        tick();
        mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'h0000_0413; ifu_rsp_ready_i = 1;
        @(negedge clk_i);
        checks++; if ({ifu_rsp_valid_o, ifu_rdata_o, mem_rsp_ready_o} !== {1'b1, 32'h0000_0413, 1'b1}) begin
            failures++; $display("FAIL rd_rsp got=%b %h %b exp=1 00000413 1", ifu_rsp_valid_o, ifu_rdata_o, mem_rsp_ready_o); end
        checks++; if ({lsu_rsp_valid_o, lsu_rdata_o} !== 33'd0) begin
            failures++; $display("FAIL rd_lsu_quiet got=%b %h exp=0 0", lsu_rsp_valid_o, lsu_rdata_o); end
        tick();
        mem_rsp_valid_i = 0;
        @(negedge clk_i);
        checks++; if ({ifu_rsp_valid_o, ifu_rdata_o, mem_req_valid_o} !== 34'd0) begin
            failures++; $display("FAIL rd_done got=%b %h %b exp=0 0 0", ifu_rsp_valid_o, ifu_rdata_o, mem_req_valid_o); end
        clear_inputs();
    endtask

    task automatic test_arbitration();
        logic [1:0] exp;
        do_reset();
        for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_RR_EN
            exp = (r % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp = 2'b10;
`endif
            ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_1000;
            lsu_req_valid_i = 1; lsu_addr_i = 32'h8000_2000; lsu_wen_i = 0;
            @(negedge clk_i);
            checks++; if ({lsu_req_ready_o, ifu_req_ready_o} !== exp) begin
                failures++; $display("FAIL arb_grant%0d got=%b exp=%b", r, {lsu_req_ready_o, ifu_req_ready_o}, exp); end
            tick();
            if (exp[1]) lsu_req_valid_i = 0; else ifu_req_valid_i = 0;
            mem_req_ready_i = 1;
            @(negedge clk_i);
            checks++; if (mem_addr_o !== (exp[1] ? 32'h8000_2000 : 32'h8000_1000)) begin
                failures++; $display("FAIL arb_addr%0d got=%h", r, mem_addr_o); end
            tick();
            mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'(r + 1);
            ifu_rsp_ready_i = 1; lsu_rsp_ready_i = 1;
            @(negedge clk_i);
            checks++; if ({lsu_rsp_valid_o, ifu_rsp_valid_o} !== exp) begin
                failures++; $display("FAIL arb_rsp%0d got=%b exp=%b", r, {lsu_rsp_valid_o, ifu_rsp_valid_o}, exp); end
            tick();
            mem_rsp_valid_i = 0;
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0008;
        tick();
        ifu_req_valid_i = 0; mem_req_ready_i = 1;
        tick();
        mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'hCAFE_0001; ifu_rsp_ready_i = 0;
        lsu_req_valid_i = 1; lsu_addr_i = 32'h8000_0200; lsu_wen_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if ({mem_rsp_ready_o, ifu_rsp_valid_o, ifu_rdata_o, lsu_req_ready_o, mem_req_valid_o} !==
                {1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b %b %h %b %b exp=0 1 cafe0001 0 0", i,
                         mem_rsp_ready_o, ifu_rsp_valid_o, ifu_rdata_o, lsu_req_ready_o, mem_req_valid_o);
            end
            tick();
        end
        ifu_rsp_ready_i = 1;
        @(negedge clk_i);
        checks++; if ({mem_rsp_ready_o, lsu_req_ready_o} !== 2'b10) begin
            failures++; $display("FAIL bp_release got=%b exp=10", {mem_rsp_ready_o, lsu_req_ready_o}); end
        tick();
        mem_rsp_valid_i = 0; ifu_rsp_ready_i = 0;
        @(negedge clk_i);
        checks++; if (lsu_req_ready_o !== 1'b1) begin failures++; $display("FAIL bp_next_accept got=%b exp=1", lsu_req_ready_o); end
        tick();
        lsu_req_valid_i = 0; mem_req_ready_i = 1;
        @(negedge clk_i);
        checks++; if ({mem_req_valid_o, mem_addr_o} !== {1'b1, 32'h8000_0200}) begin
            failures++; $display("FAIL bp_next_req got=%b %h exp=1 80000200", mem_req_valid_o, mem_addr_o); end
        tick();
        mem_req_ready_i = 0; mem_rsp_valid_i = 1; mem_rdata_i = 32'h0BAD_F00D; lsu_rsp_ready_i = 1;
        @(negedge clk_i);
        checks++; if ({lsu_rsp_valid_o, lsu_rdata_o, ifu_rsp_valid_o} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin
            failures++; $display("FAIL bp_next_rsp got=%b %h %b exp=1 0badf00d 0", lsu_rsp_valid_o, lsu_rdata_o, ifu_rsp_valid_o); end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_lsu_write();
        test_ifu_read();
        test_arbitration();
        test_backpressure();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
